// File: rtl/tdm_demux7.sv
// Receive end of a 7-slot single-line TDM link: collects slots 1..7 serially,
// publishes the frame as a parallel word and flags early-sof / gap-timeout frames.
module tdm_demux7 #(
  parameter int unsigned GAP_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sof,
  output logic [2:0] slot,
  output logic [6:0] dout,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [8:0] GAP_LIMIT = 9'(GAP_MAX);

  logic [0:0] state;
  // Slot 7 goes straight to dout, so only slots 1..6 need holding.
  logic [5:0] shadow;
  logic [7:0] gap;
  logic [8:0] gap_inc;
  logic [2:0] wr_idx;

  assign gap_inc = {1'b0, gap} + 9'd1;
  assign wr_idx  = slot - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      slot        <= 3'd0;
      shadow      <= 6'd0;
      gap         <= 8'd0;
      dout        <= 7'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (din_valid && sof) begin
            shadow[0] <= din;
            slot      <= 3'd2;
            gap       <= 8'd0;
            state     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (din_valid) begin
            gap <= 8'd0;
            if (sof) begin
              // Early restart: drop the partial frame, this beat is slot 1.
              frame_err <= 1'b1;
              shadow[0] <= din;
              slot      <= 3'd2;
            end else if (slot == 3'd7) begin
              dout        <= {din, shadow};
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
              slot        <= 3'd0;
              state       <= ST_IDLE;
            end else begin
              shadow[wr_idx] <= din;
              slot           <= slot + 3'd1;
            end
          end else begin
            gap <= gap_inc[7:0];
            if (GAP_MAX != 0 && gap_inc == GAP_LIMIT) begin
              frame_err <= 1'b1;
              slot      <= 3'd0;
              gap       <= 8'd0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          slot  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux7.sv
// Directed bench for tdm_demux7 (GAP_MAX=4): completed frames are queued as
// expectations when the slot-7 beat is driven and popped on frame_valid.
module tb_tdm_demux7;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [2:0] slot;
  logic [6:0] dout;
  logic       frame_valid;
  logic       frame_err;
  logic [7:0] frame_cnt;

  tdm_demux7 #(.GAP_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .slot       (slot),
    .dout       (dout),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] d;
    logic [7:0] c;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_fv = 0;
  int         prev_fv = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [6:0] last_dout = 7'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, then check slot/strobes and drain the scoreboard.
  task automatic drive(input logic v, input logic s, input logic d,
                       input logic [2:0] es, input logic efv, input logic efe);
    exp_t e;
    @(negedge clk);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
    cyc++;
    chk("slot", 8'(slot), 8'(es));
    chk("frame_valid", 8'(frame_valid), 8'(efv));
    chk("frame_err", 8'(frame_err), 8'(efe));
    if (frame_valid === 1'b1) begin
      prev_fv = last_fv;
      last_fv = cyc;
      if (sb.size() == 0) begin
        chk("sb_nonempty_on_valid", 8'(sb.size()), 8'd1);
      end else begin
        e = sb.pop_front();
        chk("dout", 8'(dout), 8'(e.d));
        chk("frame_cnt", frame_cnt, e.c);
      end
    end
  endtask

  task automatic send_frame(input logic [6:0] bits, input int gap_at, input int gap_len,
                            input logic err_first);
    exp_t e;
    for (int k = 1; k <= 7; k++) begin
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b0, 1'b0, 3'(k), 1'b0, 1'b0);
      if (k == 7) begin
        exp_cnt   = exp_cnt + 8'd1;
        e.d       = bits;
        e.c       = exp_cnt;
        last_dout = bits;
        sb.push_back(e);
      end
      drive(1'b1, k == 1, bits[k-1], (k == 7) ? 3'd0 : 3'(k + 1), k == 7,
            (k == 1) && err_first);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slot"}, 8'(slot), 8'd0);
    chk({tag, "_dout"}, 8'(dout), 8'd0);
    chk({tag, "_fv"}, 8'(frame_valid), 8'd0);
    chk({tag, "_fe"}, 8'(frame_err), 8'd0);
    chk({tag, "_cnt"}, frame_cnt, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
    rst       = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst       = 1'b0;
    exp_cnt   = 8'd0;
    last_dout = 7'd0;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    din_valid = 1'b0;
    sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Basic frame: slot1..7 = 0,1,0,1,0,1,1 -> 7'h6A
    send_frame(7'b1101010, 0, 0, 1'b0);
    chk("basic_dout", 8'(dout), 8'h6A);
    chk("basic_cnt", frame_cnt, 8'd1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Back-to-back frames with no idle cycle
    do_reset();
    send_frame(7'h7F, 0, 0, 1'b0);
    chk("b2b_first", 8'(dout), 8'h7F);
    send_frame(7'h00, 0, 0, 1'b0);
    chk("b2b_spacing", 8'(last_fv - prev_fv), 8'd7);
    chk("b2b_cnt", frame_cnt, 8'd2);

    // Early sof on the 5th beat
    drive(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    for (int k = 3; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b1, 3'(k), 1'b0, 1'b0);
      chk("early_dout_hold", 8'(dout), 8'(last_dout));
    end
    send_frame(7'h41, 0, 0, 1'b1);
    chk("early_dout", 8'(dout), 8'h41);

    // Gap of 3 idle cycles is tolerated with GAP_MAX=4
    send_frame(7'h2D, 4, 3, 1'b0);
    // Gap of 4 idle cycles times out
    drive(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) drive(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("timeout_dout_hold", 8'(dout), 8'(last_dout));

    // Asynchronous reset between edges after slot 5
    drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    for (int k = 3; k <= 6; k++) drive(1'b1, 1'b0, 1'b1, 3'(k), 1'b0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    send_frame(7'h35, 0, 0, 1'b0);
    chk("post_rst_dout", 8'(dout), 8'h35);

    // Stray beats in IDLE are ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("stray_dout", 8'(dout), 8'h35);

    // Counter wrap over 256 frames
    do_reset();
    for (int i = 0; i < 256; i++) send_frame(7'($urandom_range(0, 127)), 0, 0, 1'b0);
    chk("wrap_cnt", frame_cnt, 8'd0);
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux7.md
# tdm_demux7

Registered 1-to-7 time-division demultiplexer: the receive end of the single-line, 7-slot select scheme served by the 7:1 mux. It accepts one serial bit per qualified cycle and tracks the slot number (1..7) internally, so the receiver needs no select input. After all seven slots it publishes the frame as a 7-bit parallel word with a one-cycle valid strobe. It flags malformed frames: early start-of-frame, or an inter-bit gap longer than the timeout.

## Interface

Parameters:
- GAP_MAX, 15: maximum consecutive cycles without din_valid while mid-frame. Range 0..255; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit, sampled when din_valid=1.
- din_valid  in  1  qualifies din for one cycle.
- sof  in  1  start of frame; meaningful only with din_valid=1; marks din as slot 1.
- slot  out  3  next expected slot: 0 when idle, 2..7 mid-frame.
- dout  out  7  last complete frame; dout[k-1] = slot k bit.
- frame_valid  out  1  one-cycle pulse; dout updated on the same edge.
- frame_err  out  1  one-cycle pulse on a malformed or aborted frame.
- frame_cnt  out  8  count of completed frames; wraps 255->0.

## Operation

- Reset values (asynchronous):
  - state=IDLE; slot=0.
  - dout=0; shadow register=0; gap counter=0.
  - frame_valid=0; frame_err=0; frame_cnt=0.
- IDLE state:
  - din_valid & sof: shadow[0]<=din; slot<=2; gap<=0; go to COLLECT.
  - din_valid & ~sof: beat is ignored; no error.
- COLLECT state, din_valid & ~sof:
  - shadow[slot-1]<=din; gap<=0.
  - If slot==7: dout<={din, shadow[5:0]}; frame_valid=1; frame_cnt+1; slot<=0; go to IDLE.
  - Otherwise: slot<=slot+1.
- COLLECT state, din_valid & sof (early restart):
  - frame_err=1; the partial frame is discarded and dout is unchanged.
  - Then shadow[0]<=din; slot<=2; gap<=0; stay in COLLECT.
- COLLECT state, din_valid=0:
  - gap<=gap+1.
  - If GAP_MAX!=0 and gap+1==GAP_MAX: frame_err=1; slot<=0; go to IDLE.
- Only the data bits are loaded into shadow; dout changes only on frame completion.
- slot never holds 1 (slot 1 is always consumed with sof) and never holds a value above 7.
- frame_valid and frame_err are never high in the same cycle.
- Reset mid-frame: the partial frame is dropped, with no frame_valid and no frame_err.

## Timing

- All outputs are registered and change only on the rising clock edge, except under asynchronous reset.
- Latency: dout, frame_valid and frame_cnt update on the same edge that samples slot 7.
- frame_valid is high for exactly the one following cycle.
- Minimum frame length is 7 consecutive cycles.
- Back-to-back frames: sof may arrive on the cycle immediately after the slot-7 beat. It is accepted with no gap cycle and raises no error.
- Timeout: with GAP_MAX=N, the Nth consecutive idle cycle in COLLECT produces a frame_err pulse on that edge, and slot reads 0 afterwards.
- A sof arriving while frame_err is high is handled normally.

## Test plan

- Basic frame:
  - Stimulus: after reset, 7 consecutive beats (sof on the first) with bits slot1..7 = 0,1,0,1,0,1,1.
  - Response: dout=7'h6A, one frame_valid pulse, frame_cnt=1, slot sequence 2,3,4,5,6,7,0.
- Back-to-back frames:
  - Stimulus: two frames, all-ones then all-zeros, with no idle cycle between them.
  - Response: dout=7'h7F then 7'h00, two frame_valid pulses exactly 7 cycles apart, frame_cnt=2, no frame_err.
- Early sof:
  - Stimulus: sof, then 3 beats, then sof with bits 1,0,0,0,0,0,1.
  - Response: one frame_err pulse on the 5th beat; final dout=7'h41; dout unchanged until then.
- Gap tolerance and timeout (GAP_MAX=4):
  - Stimulus: a frame with 3 idle cycles between slots 3 and 4.
  - Response: completes normally.
  - Stimulus: a frame with 4 idle cycles after slot 2.
  - Response: frame_err pulse on the 4th idle edge, slot=0, no frame_valid.
- Asynchronous reset mid-frame:
  - Stimulus: assert rst between clock edges after slot 5.
  - Response: all outputs are 0 immediately; no frame_valid.
  - Stimulus: a fresh frame after reset.
  - Response: dout equals the new frame.
- Stray beats in IDLE and counter wrap:
  - Stimulus: din_valid without sof while idle.
  - Response: ignored; no error; slot stays 0.
  - Stimulus: 256 complete frames.
  - Response: frame_cnt wraps to 0.
